// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter: round-robin arbiter granting a 4-to-16 decoded resource with done/drop/watchdog release
module decoder_grant_arbiter #(
   parameter int N       = 16,
   parameter int IDX_W   = 4,
   parameter int TIMEOUT = 255,
   parameter int TMR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx, idx_nx, win;
   logic [TMR_W-1:0] timer, timer_nx;
   logic [N-1:0]     grant_nx;
   logic             valid_nx, to_nx, any, rel_a, rel_b, rel_c;
   assign any   = |req;
   assign rel_a = done;
   assign rel_b = !req[grant_idx];
   assign rel_c = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));
   // descending scan so the lowest offset from ptr wins, wrapping modulo N
   always_comb begin
      win = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[ptr + IDX_W'(i)]) win = ptr + IDX_W'(i);
   end
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      idx_nx   = grant_idx;
      timer_nx = timer;
      grant_nx = grant;
      valid_nx = grant_valid;
      to_nx    = 1'b0;
      if (state == IDLE) begin
         if (any) begin
            state_nx      = BUSY;
            idx_nx        = win;
            grant_nx      = '0;
            grant_nx[win] = 1'b1;
            valid_nx      = 1'b1;
            timer_nx      = '0;
         end
      end else begin
         timer_nx = timer + 1'b1;
         if (rel_a || rel_b || rel_c) begin
            state_nx = IDLE;
            grant_nx = '0;
            valid_nx = 1'b0;
            ptr_nx   = grant_idx + 1'b1;
            to_nx    = rel_c && !rel_a && !rel_b;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         timer       <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         timer       <= timer_nx;
         grant       <= grant_nx;
         grant_idx   <= idx_nx;
         grant_valid <= valid_nx;
         timeout     <= to_nx;
      end
   end
endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// tb_decoder_grant_arbiter: directed bench for decoder_grant_arbiter with a short watchdog
module tb_decoder_grant_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        timeout;
   int          errors = 0;
   int          checks = 0;

   decoder_grant_arbiter #(.N(16), .IDX_W(4), .TIMEOUT(4), .TMR_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      done = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      tick();
      checks++; if (grant !== 16'h0) begin errors++; $display("FAIL reset_grant got=%h want=0000", grant); end
      checks++; if (grant_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", grant_idx); end
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", grant_valid); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", timeout); end
   endtask

   task automatic test_single;
      req = 16'h0020;
      tick();
      checks++; if (grant !== 16'h0020) begin errors++; $display("FAIL single_grant got=%h want=0020", grant); end
      checks++; if (grant_idx !== 4'd5) begin errors++; $display("FAIL single_idx got=%0d want=5", grant_idx); end
      checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", grant_valid); end
      done = 1'b1;
      tick();
      done = 1'b0;
      req = '0;
      checks++; if (grant !== 16'h0) begin errors++; $display("FAIL single_release got=%h want=0000", grant); end
      checks++; if (grant_idx !== 4'd5) begin errors++; $display("FAIL single_idx_hold got=%0d want=5", grant_idx); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got=%b want=0", timeout); end
      tick();
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b want=0", grant_valid); end
   endtask

   task automatic test_round_robin;
      logic [15:0] exp;
      do_reset();
      req = 16'hFFFF;
      done = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         exp = 16'h1 << (k % 16);
         tick();
         checks++; if (grant !== exp || grant_idx !== 4'(k % 16) || grant_valid !== 1'b1) begin errors++; $display("FAIL rr_grant k=%0d got=%h/%0d want=%h/%0d", k, grant, grant_idx, exp, k % 16); end
         tick();
         checks++; if (grant !== 16'h0 || grant_valid !== 1'b0) begin errors++; $display("FAIL rr_gap k=%0d got=%h want=0000", k, grant); end
      end
      req = '0;
      done = 1'b0;
   endtask

   task automatic test_wrap_skip;
      do_reset();
      req = 16'h2000;
      tick();
      checks++; if (grant_idx !== 4'd13) begin errors++; $display("FAIL wrap_first got=%0d want=13", grant_idx); end
      done = 1'b1;
      tick();
      req = 16'h0009;
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL wrap_gap0 got=%b want=0", grant_valid); end
      tick();
      checks++; if (grant !== 16'h0001 || grant_idx !== 4'd0) begin errors++; $display("FAIL wrap_win0 got=%h/%0d want=0001/0", grant, grant_idx); end
      tick();
      tick();
      checks++; if (grant !== 16'h0008 || grant_idx !== 4'd3) begin errors++; $display("FAIL wrap_win3 got=%h/%0d want=0008/3", grant, grant_idx); end
      tick();
      tick();
      checks++; if (grant !== 16'h0001 || grant_idx !== 4'd0) begin errors++; $display("FAIL wrap_win0b got=%h/%0d want=0001/0", grant, grant_idx); end
      req = '0;
      tick();
      done = 1'b0;
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got=%b want=0", grant_valid); end
   endtask

   task automatic test_watchdog;
      do_reset();
      req = 16'h0100;
      tick();
      checks++; if (grant !== 16'h0100 || grant_valid !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL wd_start got=%h/%b/%b want=0100/1/0", grant, grant_valid, timeout); end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++; if (grant_valid !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL wd_hold k=%0d got=%b/%b want=1/0", k, grant_valid, timeout); end
      end
      tick();
      checks++; if (grant_valid !== 1'b0 || grant !== 16'h0 || timeout !== 1'b1) begin errors++; $display("FAIL wd_fire got=%b/%h/%b want=0/0000/1", grant_valid, grant, timeout); end
      tick();
      checks++; if (grant_idx !== 4'd8 || grant_valid !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL wd_regrant got=%0d/%b/%b want=8/1/0", grant_idx, grant_valid, timeout); end
   endtask

   task automatic test_coincidence;
      for (int k = 1; k < 4; k++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (grant_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL coin_done got=%b/%b want=0/0", grant_valid, timeout); end
      tick();
      checks++; if (grant_idx !== 4'd8 || grant_valid !== 1'b1) begin errors++; $display("FAIL coin_regrant got=%0d/%b want=8/1", grant_idx, grant_valid); end
      tick();
      req = 16'h00F0;
      tick();
      checks++; if (grant_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL coin_drop got=%b/%b want=0/0", grant_valid, timeout); end
      tick();
      checks++; if (grant_idx !== 4'd4 || grant !== 16'h0010) begin errors++; $display("FAIL coin_next got=%0d/%h want=4/0010", grant_idx, grant); end
      req = '0;
      tick();
   endtask

   task automatic test_async_reset;
      do_reset();
      req = 16'h0400;
      tick();
      checks++; if (grant !== 16'h0400 || grant_idx !== 4'd10) begin errors++; $display("FAIL ar_grant got=%h/%0d want=0400/10", grant, grant_idx); end
      #2 rst = 1'b1;
      #1;
      checks++; if (grant !== 16'h0 || grant_valid !== 1'b0) begin errors++; $display("FAIL ar_clear got=%h/%b want=0000/0", grant, grant_valid); end
      #1 rst = 1'b0;
      tick();
      checks++; if (grant !== 16'h0400 || grant_valid !== 1'b1) begin errors++; $display("FAIL ar_resume got=%h/%b want=0400/1", grant, grant_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_skip();
      test_watchdog();
      test_coincidence();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
